// File: rtl/gc_ref_pkg.sv
// gc_ref_pkg
// Shared definitions for the gain-cell refresh controller slice.
// Contents:
//   ref_state_t    - refresh round state (IDLE, START, COPY, COMMIT)
//   DEF_*          - default NUM_WRAP / REF_PERIOD / TIMEOUT values
//   ROWS, DATA_W   - geometry of one gain-cell wrapper (128 x 64)
//   lbank_width()  - width of a logical bank index, never below 1
package gc_ref_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    COPY   = 2'd2,
    COMMIT = 2'd3
  } ref_state_t;

  localparam int DEF_NUM_WRAP   = 4;
  localparam int DEF_REF_PERIOD = 1024;
  localparam int DEF_TIMEOUT    = 512;

  localparam int ROWS   = 128;
  localparam int DATA_W = 64;

  // One wrapper is always the spare, so there are num_wrap-1 logical banks.
  // A single logical bank still needs a 1-bit index port.
  function automatic int lbank_width(input int num_wrap);
    return (num_wrap - 1 > 1) ? $clog2(num_wrap - 1) : 1;
  endfunction

endpackage

// File: rtl/gc_refresh_ctrl_timer.sv
// ref_period_timer
// Free-running refresh period counter plus the coalescing pending flag.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   ref_force  - single-cycle request for an extra refresh round
//   clr        - the controller accepted the pending request this cycle
//   pending    - at least one refresh request is outstanding
module ref_period_timer
  import gc_ref_pkg::*;
#(
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  localparam int CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic ref_force,
  input  logic clr,
  output logic pending
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             expire;

  assign expire = (cnt == LAST);

  // Period counter wraps at REF_PERIOD-1 and never stops, whatever the
  // controller is doing, so the refresh cadence stays fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Any number of requests collapse into one pending bit. A new request in
  // the same cycle as the accept keeps the bit set so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else begin
      pending <= expire | ref_force | (pending & ~clr);
    end
  end

endmodule

// File: rtl/gc_refresh_ctrl.sv
// gc_refresh_ctrl
// Refresh controller for NUM_WRAP gain-cell wrappers, one of which is always
// a spare. Each round copies one logical bank from its current wrapper (old
// side) into the spare (current side), then remaps the bank to the spare and
// makes the old wrapper the new spare.
// Optional feature macro: GC_REF_TIMEOUT_EN - abort a COPY that sees no
// ref_done within TIMEOUT cycles and raise the sticky ref_err flag.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   ref_force       - single-cycle request for an immediate extra round
//   ref_done        - per-wrapper refresh-complete indication
//   u_lbank         - user logical bank
//   u_pbank         - physical wrapper currently holding u_lbank
//   start_sr        - one-hot 1-cycle start pulse to the destination wrapper
//   ref_en_current  - one-hot select of the destination wrapper
//   ref_en_old      - one-hot select of the source wrapper
//   busy            - a refresh round is in progress
//   ref_err         - sticky COPY timeout flag (0 without the macro)
module gc_refresh_ctrl
  import gc_ref_pkg::*;
#(
  parameter int NUM_WRAP   = DEF_NUM_WRAP,
  parameter int REF_PERIOD = DEF_REF_PERIOD,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  localparam int PB_W = $clog2(NUM_WRAP),
  localparam int LB_W = lbank_width(NUM_WRAP)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ref_force,
  input  logic [NUM_WRAP-1:0] ref_done,
  input  logic [LB_W-1:0]     u_lbank,
  output logic [PB_W-1:0]     u_pbank,
  output logic [NUM_WRAP-1:0] start_sr,
  output logic [NUM_WRAP-1:0] ref_en_current,
  output logic [NUM_WRAP-1:0] ref_en_old,
  output logic                busy,
  output logic                ref_err
);

  localparam int                  NUM_LB   = NUM_WRAP - 1;
  localparam logic [NUM_WRAP-1:0] ONE_HOT0 = NUM_WRAP'(1);
  localparam logic [LB_W-1:0]     LIDX_MAX = LB_W'(NUM_WRAP - 2);

  ref_state_t      state;
  logic [PB_W-1:0] bank_map [NUM_LB];
  logic [PB_W-1:0] spare;
  logic [PB_W-1:0] src;
  logic [PB_W-1:0] dst;
  logic [LB_W-1:0] lidx;
  logic            pending;
  logic            clr_pending;
  logic            copy_expired;

  assign clr_pending = (state == IDLE) && pending;
  assign busy        = (state != IDLE);

  ref_period_timer #(
    .REF_PERIOD(REF_PERIOD)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ref_force(ref_force),
    .clr      (clr_pending),
    .pending  (pending)
  );

  // User routing reads the live map. During a round it still points at the
  // source wrapper; the new mapping appears once COMMIT has written it.
  always_comb begin
    u_pbank = '0;
    if (int'(u_lbank) < NUM_LB) begin
      u_pbank = bank_map[u_lbank];
    end
  end

`ifdef GC_REF_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;

  assign copy_expired = (to_cnt == TO_W'(TIMEOUT - 1));

  // COPY watchdog: counts COPY cycles from zero and latches ref_err when a
  // round is abandoned. Completion on the last cycle takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      ref_err <= 1'b0;
    end else if (state == COPY) begin
      to_cnt <= to_cnt + TO_W'(1);
      if (!ref_done[dst] && copy_expired) begin
        ref_err <= 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign copy_expired = 1'b0;
  assign ref_err      = 1'b0;
`endif

  // Round sequencer. Selects are registered here alongside the state so they
  // are glitch-free and line up with START/COPY exactly. src and dst are
  // latched at the IDLE->START transition and stay stable for the round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      for (int i = 0; i < NUM_LB; i++) begin
        bank_map[i] <= PB_W'(i);
      end
      spare          <= PB_W'(NUM_WRAP - 1);
      src            <= '0;
      dst            <= '0;
      lidx           <= '0;
      start_sr       <= '0;
      ref_en_current <= '0;
      ref_en_old     <= '0;
    end else begin
      start_sr <= '0;
      case (state)
        IDLE: begin
          if (pending) begin
            src            <= bank_map[lidx];
            dst            <= spare;
            start_sr       <= ONE_HOT0 << spare;
            ref_en_current <= ONE_HOT0 << spare;
            ref_en_old     <= ONE_HOT0 << bank_map[lidx];
            state          <= START;
          end
        end
        START: begin
          state <= COPY;
        end
        COPY: begin
          if (ref_done[dst]) begin
            ref_en_current <= '0;
            ref_en_old     <= '0;
            state          <= COMMIT;
          end else if (copy_expired) begin
            ref_en_current <= '0;
            ref_en_old     <= '0;
            state          <= IDLE;
          end
        end
        COMMIT: begin
          bank_map[lidx] <= dst;
          spare          <= src;
          lidx           <= (lidx == LIDX_MAX) ? '0 : lidx + LB_W'(1);
          state          <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gc_refresh_ctrl.sv
// tb_gc_refresh_ctrl
// Directed self-checking bench for gc_refresh_ctrl with NUM_WRAP=4,
// REF_PERIOD=16, TIMEOUT=8. Timeout scenarios are included when
// GC_REF_TIMEOUT_EN is defined.
module tb_gc_refresh_ctrl;

  localparam int NW = 4;
  localparam int RP = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          ref_force;
  logic [NW-1:0] ref_done;
  logic [1:0]    u_lbank;
  logic [1:0]    u_pbank;
  logic [NW-1:0] start_sr;
  logic [NW-1:0] ref_en_current;
  logic [NW-1:0] ref_en_old;
  logic          busy;
  logic          ref_err;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc        = 0;

  gc_refresh_ctrl #(
    .NUM_WRAP  (NW),
    .REF_PERIOD(RP),
    .TIMEOUT   (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ref_force     (ref_force),
    .ref_done      (ref_done),
    .u_lbank       (u_lbank),
    .u_pbank       (u_pbank),
    .start_sr      (start_sr),
    .ref_en_current(ref_en_current),
    .ref_en_old    (ref_en_old),
    .busy          (busy),
    .ref_err       (ref_err)
  );

  always #5 clk = ~clk;

  // Reference model of the period counter: edges since reset release.
  // A timer request is registered on edges where cyc % RP == 0.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic frc, input logic [NW-1:0] done);
    ref_force = frc;
    ref_done  = done;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_selects(input string tag, input logic [NW-1:0] s,
                               input logic [NW-1:0] c, input logic [NW-1:0] o,
                               input logic b);
    checkOutput({tag, ".start_sr"}, 32'(start_sr), 32'(s));
    checkOutput({tag, ".en_cur"}, 32'(ref_en_current), 32'(c));
    checkOutput({tag, ".en_old"}, 32'(ref_en_old), 32'(o));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  task automatic check_map(input string tag, input int m0, input int m1, input int m2);
    u_lbank = 2'd0; #1 checkOutput({tag, ".map0"}, 32'(u_pbank), m0);
    u_lbank = 2'd1; #1 checkOutput({tag, ".map1"}, 32'(u_pbank), m1);
    u_lbank = 2'd2; #1 checkOutput({tag, ".map2"}, 32'(u_pbank), m2);
    u_lbank = 2'd3; #1 checkOutput({tag, ".oor"}, 32'(u_pbank), 0);
    u_lbank = 2'd0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start_sr == '0 && n < 40) begin
      tick();
      n++;
    end
    checkOutput({tag, ".start_seen"}, (start_sr != '0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_round(input string tag, input int src, input int dst,
                          input int copy_cycles);
    logic [NW-1:0] s_oh;
    logic [NW-1:0] d_oh;
    s_oh = NW'(1) << src;
    d_oh = NW'(1) << dst;
    wait_start(tag);
    check_selects({tag, ".start"}, d_oh, d_oh, s_oh, 1'b1);
    tick();
    check_selects({tag, ".copy"}, '0, d_oh, s_oh, 1'b1);
    repeat (copy_cycles - 1) tick();
    applyStimulus(1'b0, d_oh);
    tick();
    check_selects({tag, ".commit"}, '0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0);
    tick();
    checkOutput({tag, ".idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    logic idle_ok;
    int   n;
    rst     = 1'b1;
    u_lbank = 2'd0;
    applyStimulus(1'b0, '0);
    repeat (2) @(negedge clk);

    check_selects("reset", '0, '0, '0, 1'b0);
    checkOutput("reset.ref_err", 32'(ref_err), 0);
    check_map("reset", 0, 1, 2);

    rst = 1'b0;

    // Round 1: timer driven, src 0 -> dst 3.
    repeat (15) tick();
    check_selects("r1.pre", '0, '0, '0, 1'b0);
    tick();
    check_selects("r1.pending", '0, '0, '0, 1'b0);
    tick();
    check_selects("r1.start", 4'b1000, 4'b1000, 4'b0001, 1'b1);
    checkOutput("r1.start.map0", 32'(u_pbank), 0);
    tick();
    check_selects("r1.copy", '0, 4'b1000, 4'b0001, 1'b1);
    applyStimulus(1'b0, 4'b0010);
    tick();
    check_selects("r1.nondst", '0, 4'b1000, 4'b0001, 1'b1);
    applyStimulus(1'b0, 4'b1000);
    tick();
    check_selects("r1.commit", '0, '0, '0, 1'b1);
    checkOutput("r1.commit.map0", 32'(u_pbank), 0);
    applyStimulus(1'b0, '0);
    tick();
    checkOutput("r1.idle_busy", 32'(busy), 0);
    check_map("r1", 3, 1, 2);

    // Rounds 2 and 3 complete the first pass over the logical banks.
    do_round("r2", 1, 0, 1);
    check_map("r2", 3, 0, 2);
    do_round("r3", 2, 1, 3);
    check_map("r3", 3, 0, 1);

    // Round 4 is forced so that two more forces and one timer expiry all
    // land inside its COPY; they must yield exactly one extra round.
    n = 0;
    while (cyc % RP != 11 && n < 40) begin
      tick();
      n++;
    end
    applyStimulus(1'b1, '0);
    tick();
    applyStimulus(1'b0, '0);
    checkOutput("r4.pending_busy", 32'(busy), 0);
    tick();
    check_selects("r4.start", 4'b0100, 4'b0100, 4'b1000, 1'b1);
    tick();
    check_selects("r4.copy", '0, 4'b0100, 4'b1000, 1'b1);
    applyStimulus(1'b1, '0);
    tick();
    applyStimulus(1'b0, '0);
    tick();
    checkOutput("r4.expiry_copy", 32'(ref_en_current), 32'(4'b0100));
    applyStimulus(1'b1, '0);
    tick();
    applyStimulus(1'b0, 4'b0100);
    tick();
    check_selects("r4.commit", '0, '0, '0, 1'b1);
    applyStimulus(1'b0, '0);
    tick();
    checkOutput("r4.gap_busy", 32'(busy), 0);
    check_map("r4", 2, 0, 1);

    do_round("r5", 0, 3, 1);
    check_map("r5", 2, 3, 1);

    idle_ok = 1'b1;
    n = 0;
    while (cyc % RP != 0 && n < 40) begin
      tick();
      if (busy !== 1'b0) idle_ok = 1'b0;
      n++;
    end
    checkOutput("coalesce.no_extra", 32'(idle_ok), 1);

    do_round("r6", 1, 0, 1);
    check_map("r6", 2, 3, 0);

`ifdef GC_REF_TIMEOUT_EN
    // Round 7 never sees ref_done: aborted after 8 COPY cycles.
    wait_start("r7");
    check_selects("r7.start", 4'b0010, 4'b0010, 4'b0100, 1'b1);
    tick();
    repeat (7) tick();
    check_selects("r7.copy_last", '0, 4'b0010, 4'b0100, 1'b1);
    checkOutput("r7.err_pre", 32'(ref_err), 0);
    tick();
    check_selects("r7.abort", '0, '0, '0, 1'b0);
    checkOutput("r7.err", 32'(ref_err), 1);
    check_map("r7", 2, 3, 0);

    // Retry of the same logical bank.
    do_round("r8", 2, 1, 1);
    check_map("r8", 1, 3, 0);
    checkOutput("r8.err_sticky", 32'(ref_err), 1);
`endif

    // Asynchronous reset in the middle of COPY.
    wait_start("rr");
    tick();
    checkOutput("rr.copy_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check_selects("rr.async", '0, '0, '0, 1'b0);
    checkOutput("rr.ref_err", 32'(ref_err), 0);
    check_map("rr", 0, 1, 2);
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/gc_refresh_ctrl.md
Name: gc_refresh_ctrl

Overview:
- Refresh controller that drives the wrapper-side refresh interface of an array of NUM_WRAP 128x64 gain-cell memory wrappers.
- One physical wrapper is always a spare. Each refresh round copies one logical bank from its physical wrapper (the "old"/COI side) into the spare (the "current" side). The controller then re-maps that logical bank to the spare.
- Owns the refresh period timer, the per-round start_SR pulse, the ref_en_current/ref_en_old selects, the done handshake, and the logical-to-physical bank map used by user-side routing.

Parameters:
- NUM_WRAP, 4, physical wrappers (>=2); logical banks = NUM_WRAP-1
- REF_PERIOD, 1024, cycles between refresh round requests (>=2)
- TIMEOUT, 512, max cycles in COPY before abort (used only with GC_REF_TIMEOUT_EN)
- Derived: PB_W = $clog2(NUM_WRAP); LB_W = max(1, $clog2(NUM_WRAP-1))

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ref_force  in  1  single-cycle request for an immediate extra refresh round
- ref_done  in  NUM_WRAP  per-wrapper refresh-complete indication
- u_lbank  in  LB_W  user logical bank
- u_pbank  out  PB_W  physical wrapper currently holding u_lbank
- start_sr  out  NUM_WRAP  one-hot, 1-cycle start pulse to the destination wrapper's shift register
- ref_en_current  out  NUM_WRAP  one-hot, marks the destination wrapper (the one being refreshed)
- ref_en_old  out  NUM_WRAP  one-hot, marks the source wrapper (COI)
- busy  out  1  round in progress (state != IDLE)
- ref_err  out  1  sticky timeout flag (constant 0 without GC_REF_TIMEOUT_EN)

Behaviour:
- Reset (async):
  - map[i] = i for i < NUM_WRAP-1; spare = NUM_WRAP-1; lidx = 0; period counter = 0; pending = 0; state = IDLE.
  - All outputs 0 except u_pbank, which follows the map.
- Timer:
  - Counts 0..REF_PERIOD-1 and wraps. Counting continues in every state.
  - On reaching REF_PERIOD-1, or on ref_force=1, pending is set to 1.
  - Multiple requests are coalesced into a single pending bit.
  - If pending is cleared and set in the same cycle, set wins.
- State machine, states IDLE, START, COPY, COMMIT:
  - IDLE: if pending, latch src = map[lidx] and dst = spare, clear pending, go to START.
  - START (1 cycle): start_sr[dst] = 1; ref_en_current[dst] = 1; ref_en_old[src] = 1. Go to COPY.
  - COPY: ref_en_current[dst] and ref_en_old[src] stay high. ref_done[dst] is ignored in START and sampled from the first COPY cycle. On ref_done[dst] = 1, go to COMMIT. ref_done on any other wrapper is ignored.
  - COMMIT (1 cycle, all selects low): map[lidx] <= dst; spare <= src; lidx <= (lidx == NUM_WRAP-2) ? 0 : lidx+1. Go to IDLE.
- Latency and throughput:
  - Pending to start_sr: 1 cycle (the pulse appears the cycle after the IDLE cycle that sees pending).
  - Minimum round length is 4 cycles (IDLE, START, COPY, COMMIT).
  - A request that arrives during a round starts the next round right after COMMIT+IDLE.
- Output invariants:
  - start_sr, ref_en_current and ref_en_old are registered, one-hot or zero.
  - src != dst always.
- User routing:
  - u_pbank = map[u_lbank], combinational.
  - During START/COPY it still returns src; the wrapper forwards user writes to dst.
  - The map update becomes visible on u_pbank the cycle after COMMIT.
  - u_lbank >= NUM_WRAP-1 returns 0.
- Reset mid-round: the map reverts to identity and all selects drop asynchronously. The wrapper data is then considered invalid.

Optional Feature:
- GC_REF_TIMEOUT_EN defined:
  - A cycle counter runs while in COPY.
  - At TIMEOUT cycles without ref_done[dst]: set ref_err (sticky until rst), go to IDLE without a map update, and leave lidx unchanged. The round is retried on the next pending request.
- Not defined: COPY waits indefinitely; ref_err is tied to 0; no counter logic.

Decomposition:
- Package gc_ref_pkg: state enum (IDLE, START, COPY, COMMIT), default NUM_WRAP/REF_PERIOD/TIMEOUT constants, ROWS=128 and DATA_W=64 constants.
- Sub-module ref_period_timer: counter plus pending/coalesce logic; inputs clk, rst, ref_force, clr; output pending.

Test Plan (NUM_WRAP=4, REF_PERIOD=16, TIMEOUT=8):
- Reset, idle 15 cycles -> pending at cycle 15; start_sr=4'b1000 and ref_en_old=4'b0001 one cycle later; u_pbank for lbank 0 = 0.
- Assert ref_done[3] two cycles into COPY -> COMMIT; afterwards map[0]=3, spare=0; u_lbank=0 -> u_pbank=3; lidx=1.
- Run 3 full rounds -> lidx wraps 2->0; final map {3,0,1}, spare 2; start_sr one-hot every round.
- ref_force twice plus a timer expiry during a round -> exactly one extra round follows; busy drops for one IDLE cycle between rounds.
- ref_done[1] (non-dst) pulsed during COPY with dst=3 -> ignored, state stays COPY.
- With GC_REF_TIMEOUT_EN: withhold ref_done 8 COPY cycles -> ref_err=1, map unchanged, back to IDLE; async rst mid-COPY -> all outputs 0 immediately.
